// File: rtl/game_event_logger.sv
// game_event_logger
// Samples the game-status stage every clock, turns each scoring event into a
// timestamped record and queues it in a FIFO that is drained over a
// valid/ready stream. Lost records are reported through a sticky overflow
// flag and a saturating drop counter.
module game_event_logger #(
    parameter int DEPTH    = 8,   // FIFO entries, power of 2, >= 2
    parameter int TS_WIDTH = 12   // free-running timestamp width
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      win,
    input  logic                      los,
    input  logic                      gameover,
    input  logic [1:0]                who,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [TS_WIDTH+3:0]       ev_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [7:0]                drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = TS_WIDTH + 4;

    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    // record kind encodings
    localparam logic [1:0] KIND_LOSS = 2'b01;
    localparam logic [1:0] KIND_WIN  = 2'b10;
    localparam logic [1:0] KIND_GO   = 2'b11;

    // reset and soft clear act identically; reset dominates trivially
    logic flush;
    assign flush = !reset_n || clear;

    // timestamp and gameover edge history
    logic [TS_WIDTH-1:0] ts;
    logic                go_prev;

    // single-entry holding slot for a gameover record that lost arbitration
    logic                pend_valid;
    logic [RW-1:0]       pend_rec;

    // FIFO storage
    logic [RW-1:0]       mem [DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;

    // per-cycle decisions
    logic                go_edge;
    logic                wl_event;
    logic [RW-1:0]       wl_rec;
    logic [RW-1:0]       go_rec;
    logic                pop;
    logic                room;
    logic                push;
    logic [RW-1:0]       push_rec;
    logic                pend_load;
    logic                pend_take;
    logic                drop_wl;
    logic                drop_go;
    logic [8:0]          drop_sum;

    assign ev_valid = (level != '0);
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

    // Arbitrate the single push slot: pending gameover first, then win/loss,
    // then a fresh gameover edge. A push fits when the FIFO has a free entry
    // or the head leaves in the same cycle.
    always_comb begin
        go_edge   = gameover && !go_prev;
        wl_event  = win || los;
        // win dominates when both levels are (illegally) high together
        wl_rec    = {(win ? KIND_WIN : KIND_LOSS), 2'b00, ts};
        go_rec    = {KIND_GO, who, ts};
        pop       = ev_valid && ev_ready;
        room      = (level < LEVEL_FULL) || pop;

        push      = 1'b0;
        push_rec  = pend_rec;
        pend_load = 1'b0;
        pend_take = 1'b0;
        drop_wl   = 1'b0;
        drop_go   = 1'b0;

        if (pend_valid) begin
            // the held gameover owns the slot; anything new this cycle is lost
            if (room) begin
                push      = 1'b1;
                pend_take = 1'b1;
            end
            drop_wl = wl_event;
            drop_go = go_edge;
        end else begin
            if (wl_event) begin
                if (room) begin
                    push     = 1'b1;
                    push_rec = wl_rec;
                end else begin
                    drop_wl = 1'b1;
                end
                // a coincident gameover edge waits one slot behind
                pend_load = go_edge;
            end else if (go_edge) begin
                if (room) begin
                    push     = 1'b1;
                    push_rec = go_rec;
                end else begin
                    pend_load = 1'b1;
                end
            end
        end

        drop_sum = {1'b0, drop_count} + 9'(drop_wl) + 9'(drop_go);
    end

    // free-running timestamp and gameover history
    always_ff @(posedge clk) begin
        if (flush) begin
            ts      <= '0;
            go_prev <= 1'b0;
        end else begin
            ts      <= ts + 1'b1;
            go_prev <= gameover;
        end
    end

    // pending gameover slot: loaded on a blocked edge, freed once pushed
    always_ff @(posedge clk) begin
        if (flush) begin
            pend_valid <= 1'b0;
            pend_rec   <= '0;
        end else if (pend_load) begin
            pend_valid <= 1'b1;
            pend_rec   <= go_rec;
        end else if (pend_take) begin
            pend_valid <= 1'b0;
        end
    end

    // FIFO storage write; contents are don't-care while level is zero
    always_ff @(posedge clk) begin
        if (!flush && push) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // sticky overflow flag and saturating drop counter
    always_ff @(posedge clk) begin
        if (flush) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop_wl || drop_go) overflow <= 1'b1;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

// File: doc/game_event_logger.md
# game_event_logger

Downstream consumer of the game-status stage. Samples its `win`, `los`, `gameover` and `who` outputs every clock, converts each scoring event into a timestamped record, and buffers the records in a FIFO. Records are drained over a valid/ready stream toward the reporting/host side. Overflow is tracked so that lost events are visible to software and to the bench.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; a power of 2, ≥ 2.
- `TS_WIDTH`, 12: width of the free-running cycle timestamp.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `clear`  in  1  synchronous soft clear; same effect as reset, active-high.
- `win`  in  1  winner level from the game-status stage.
- `los`  in  1  loser level from the game-status stage.
- `gameover`  in  1  game-over flag from the game-status stage.
- `who`  in  2  `01` means the loser count hit 15, `10` means the winner count hit 15.
- `ev_valid`  out  1  head record available.
- `ev_ready`  in  1  consumer accepts the head record.
- `ev_data`  out  `4+TS_WIDTH`  record `{kind[1:0], who[1:0], ts[TS_WIDTH-1:0]}`.
- `level`  out  `$clog2(DEPTH)+1`  number of occupied entries.
- `overflow`  out  1  sticky; set when any record was dropped.
- `drop_count`  out  8  saturating count of dropped records.

## Operation
- **Timestamp `ts`**
  - Increments every cycle and wraps from `2^TS_WIDTH-1` to 0.
  - A record carries the `ts` value present in the sampling cycle, i.e. the value before that edge's increment.
- **Record kinds**
  - `01` loss: `los`=1 in the cycle. The `who` field is `00`.
  - `10` win: `win`=1 in the cycle. The `who` field is `00`.
  - `11` gameover: rising edge of `gameover` (0 in the previous cycle, 1 now). The `who` field is the sampled `who`.
- **Levels are per cycle.** `win` and `los` are levels, and one record is produced for every cycle in which either is high. This mirrors the upstream counters, which increment every such cycle.
- **`win` and `los` together:** only the win record is produced. This is an illegal upstream state, but the behaviour is defined.
- **Push path:** at most one FIFO push per cycle.
  - Priority order: pending gameover, then win/loss, then a new gameover edge.
  - A gameover edge that cannot be pushed in its own cycle is held in a 1-entry pending slot (`pend`) together with its `ts` and `who`.
  - `pend` is pushed at the first cycle that has FIFO space.
- **Push acceptance:** a push is accepted when `level < DEPTH`, or when a pop occurs in the same cycle.
- **Full FIFO:**
  - A win/loss record is dropped: `overflow` is set to 1 and `drop_count` increments, saturating at 255.
  - A gameover record is never dropped; it waits in `pend`.
  - A new gameover edge while `pend` is occupied is dropped and counted.
- **Pop:** `ev_valid && ev_ready` removes the head. `ev_data` shows the head record and is 0 when the FIFO is empty.
- **`level`:** incremented by a push, decremented by a pop, unchanged when both occur.
- **Reset or `clear`:**
  - Empties the FIFO and `pend`.
  - Sets `ts`, `overflow` and `drop_count` to 0.
  - Sets the `gameover` edge history to 0.
  - Any event sampled in that cycle is ignored.
  - `clear` has no effect while `reset_n`=0.

## Timing
- **Reset values:** `ev_valid`=0, `ev_data`=0, `level`=0, `overflow`=0, `drop_count`=0. Internal `ts`=0, `pend` empty.
- **Latency:** an event sampled at edge N appears at `ev_valid`/`ev_data` after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- **Stability:** while `ev_valid`=1 and `ev_ready`=0, `ev_data` holds stable. `ev_valid` never drops without a pop, except on reset or `clear`.
- **Throughput:** one push and one pop per cycle sustained.
- **Gameover with win/loss in the same cycle:** the win/loss record is pushed in that cycle and the gameover record in the next cycle. The gameover record keeps its original `ts`.
- **Reset in mid-stream:** the stream is abandoned. The consumer sees `ev_valid`=0 in the cycle after the reset edge.

## Test plan
- **Reset state:** hold `reset_n`=0 for 3 cycles with `win`=1. Expect `ev_valid`=0, `level`=0 and `drop_count`=0 throughout, and after release `ev_data` equals `{10,00,ts=0}` in the first cycle.
- **Mixed event sequence:** with `ev_ready`=1, pulse `los` at `ts`=5 and `win` at `ts`=9, then idle. Expect records `{01,00,5}` and `{10,00,9}` in order, each one cycle after sampling, and `level` returns to 0.
- **Overflow:** `DEPTH`=8, `ev_ready`=0, `win`=1 for 12 cycles. Expect `level`=8 and `overflow`=1 after the 9th push attempt, and `drop_count`=4. Then drain and check that the `ts` values of the 8 retained records are consecutive.
- **Gameover collision:** `win`=1 and a `gameover` rise with `who`=`10` in the same cycle at `ts`=20. Expect `{10,00,20}` followed by `{11,10,20}`.
- **Gameover held while full:** FIFO full with `ev_ready`=0, then a `gameover` rise with `who`=`01`. Expect no drop for the gameover. Assert `ev_ready` for 1 cycle: expect the gameover record to enter the FIFO that cycle and to be last in drain order.
- **`clear` with wrap:** run `TS_WIDTH`=4 for 18 cycles and log `win` at the 17th cycle; expect `ts`=0 on that record because `ts` wrapped. Then assert `clear` with 3 entries queued: expect `level`=0, `overflow`=0 and `ts` restarting from 0.
